cp0_ctrl: RTL

- Coprocessor-0 exception/interrupt controller for the P7 five-stage MIPS core; sits beside the M stage.
- Produces the pipeline-wide flush request `Req`. The F, D, E, M and W pipeline registers consume `Req`; the W register flushes and loads PC 0x0000_4180 on it.
- Holds SR, Cause, EPC and PRId. Serves `mfc0`/`mtc0`, and supplies EPC to `eret`.

---
 rtl/cp0_ctrl.sv | 108 ++++++++++
 1 files changed

// File: rtl/cp0_ctrl.sv
// rtl/cp0_ctrl.sv - CP0 exception/interrupt controller: SR, Cause, EPC, PRId and pipeline flush request.
module cp0_ctrl #(
  parameter logic [31:0] PRID     = 32'h0000_4350,
  parameter logic [5:0]  IM_RESET = 6'b000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  A1,
  input  logic [4:0]  A2,
  input  logic [31:0] DIn,
  input  logic        WE,
  input  logic [31:0] PC,
  input  logic        BDIn,
  input  logic [4:0]  ExcCodeIn,
  input  logic        EXLClr,
  input  logic [5:0]  HWInt,
  output logic        Req,
  output logic [31:0] EPCOut,
  output logic [31:0] DOut
);

  logic [5:0]  im_q, im_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  logic        bd_q, bd_d;
  logic [5:0]  ip_q, ip_d;
  logic [4:0]  exc_code_q, exc_code_d;
  logic [31:0] epc_q, epc_d;

  logic        int_req;
  logic        exc_req;
  logic [31:0] victim_pc;
  logic [31:0] sr_word;
  logic [31:0] cause_word;

  assign int_req   = (|(HWInt & im_q)) & ie_q & ~exl_q;
  assign exc_req   = (ExcCodeIn != 5'd0) & ~exl_q;
  assign Req       = int_req | exc_req;
  assign victim_pc = {PC[31:2], 2'b00};

  assign sr_word    = {16'b0, im_q, 8'b0, exl_q, ie_q};
  assign cause_word = {bd_q, 15'b0, ip_q, 3'b0, exc_code_q, 2'b00};

  // A committing mtc0 EPC is forwarded so a following eret sees it without a bubble.
  assign EPCOut = (WE && !Req && A2 == 5'd14) ? DIn : epc_q;

  always_comb begin
    DOut = 32'd0;
    case (A1)
      5'd12:   DOut = sr_word;
      5'd13:   DOut = cause_word;
      5'd14:   DOut = epc_q;
      5'd15:   DOut = PRID;
      default: DOut = 32'd0;
    endcase
  end

  always_comb begin
    im_d       = im_q;
    exl_d      = exl_q;
    ie_d       = ie_q;
    bd_d       = bd_q;
    ip_d       = HWInt;
    exc_code_d = exc_code_q;
    epc_d      = epc_q;
    if (Req) begin
      // The victim instruction does not commit, so any mtc0 alongside it is dropped.
      exl_d      = 1'b1;
      exc_code_d = int_req ? 5'd0 : ExcCodeIn;
      bd_d       = BDIn;
      epc_d      = BDIn ? victim_pc - 32'd4 : victim_pc;
    end else begin
      if (WE) begin
        case (A2)
          5'd12: begin
            im_d  = DIn[15:10];
            exl_d = DIn[1];
            ie_d  = DIn[0];
          end
          5'd14:   epc_d = DIn;
          default: ;
        endcase
      end
      if (EXLClr) exl_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      im_q       <= IM_RESET;
      exl_q      <= 1'b0;
      ie_q       <= 1'b0;
      bd_q       <= 1'b0;
      ip_q       <= 6'd0;
      exc_code_q <= 5'd0;
      epc_q      <= 32'd0;
    end else begin
      im_q       <= im_d;
      exl_q      <= exl_d;
      ie_q       <= ie_d;
      bd_q       <= bd_d;
      ip_q       <= ip_d;
      exc_code_q <= exc_code_d;
      epc_q      <= epc_d;
    end
  end

endmodule
